wfi_sleep_ctrl: RTL and testbench
=================================

# wfi_sleep_ctrl

Sequences the core's entry into and exit from WFI low-power state. On a retired WFI instruction it drains outstanding fetch and memory traffic, then asserts the architectural `wfi` status signal and optionally gates the core clock. It wakes on any pending enabled interrupt, bus-error, debug or CLINT interrupt, then hands control back to the pipeline. It sits between the core's retire/CSR logic and the clock-gating cell, and is the producer of the `wfi` signal consumed by the testbench WFI checker.

## Interface
- `PCWIDTH`, 32: width of `reg_mie`/`reg_mip`.
- `DRAIN_TIMEOUT`, 100: DRAIN cycles before `drain_timeout_err` is set; 1..65535.
- `WAKE_CYCLES`, 2: cycles held in WAKE after ungating before `wfi_done`; 1..15.

- `clock` in 1: core clock (ungated).
- `reset_n` in 1: asynchronous, active-low reset.
- `wfi_req` in 1: single-cycle pulse, WFI instruction retired.
- `fetch_outstanding` in 1: fetch unit has in-flight requests.
- `mem_outstanding` in 1: LSU has in-flight requests.
- `reg_mie` in PCWIDTH: mie CSR.
- `reg_mip` in PCWIDTH: mip CSR.
- `bus_err_int`, `debug_int`, `clint_int` in 1 each: wake sources.
- `debug` in 1: core in debug mode.
- `single_step` in 1: dcsr.step active.
- `wfi` out 1: core is in WFI sleep (registered).
- `core_clk_en` out 1: enable to core clock gate; 0 = gated.
- `wfi_stall` out 1: hold pipeline issue; high in DRAIN, SLEEP and WAKE.
- `wfi_done` out 1: single-cycle pulse, pipeline may resume.
- `drain_timeout_err` out 1: sticky, drain exceeded `DRAIN_TIMEOUT`.

## Operation
- `pending` = |(reg_mie & reg_mip) | bus_err_int | debug_int | clint_int. This is combinational and ignores mstatus.MIE.
- `drained` = !fetch_outstanding & !mem_outstanding.
- States: IDLE, DRAIN, SLEEP, WAKE. Encoding is free.
- IDLE:
  - `wfi_req & (pending | debug | single_step)`: stay IDLE and pulse `wfi_done` next cycle, so WFI behaves as a NOP.
  - `wfi_req` otherwise: go to DRAIN and clear the drain counter.
- DRAIN:
  - `pending`: go to WAKE. `wfi` is never asserted.
  - else `drained`: go to SLEEP.
  - else increment the 16-bit counter, saturating. When the counter equals `DRAIN_TIMEOUT`, set `drain_timeout_err` and keep waiting.
- SLEEP:
  - `wfi`=1.
  - `core_clk_en`=0 (see Configuration).
  - `pending`: go to WAKE.
- WAKE:
  - `core_clk_en`=1, `wfi`=0.
  - Count `WAKE_CYCLES`, then pulse `wfi_done` and go to IDLE.
- `wfi_req` outside IDLE is ignored.
- `pending` has priority over `drained` in the same cycle.
- `drain_timeout_err` clears only on reset.

## Timing
- Reset values: state IDLE, `wfi`=0, `core_clk_en`=1, `wfi_stall`=0, `wfi_done`=0, `drain_timeout_err`=0, counters 0.
- All outputs are registered and decoded from next-state. `wfi_stall` rises the cycle after `wfi_req`.
- Fastest sleep entry: `wfi_req` at cycle N with `drained`=1 gives DRAIN at N+1 and `wfi`=1 / `core_clk_en`=0 at N+2.
- Wake: `pending` seen at cycle M in SLEEP gives `wfi`=0 and `core_clk_en`=1 at M+1. `wfi_done` pulses at M+1+WAKE_CYCLES, and `wfi_stall` falls the same cycle.
- NOP case: `wfi_req` with `pending` at N gives `wfi_done` at N+1. `wfi_stall` stays 0.
- Timeout: `drain_timeout_err` rises DRAIN_TIMEOUT+1 cycles after DRAIN entry.
- Reset asserted mid-SLEEP immediately forces `core_clk_en`=1 and `wfi`=0 (asynchronous). No `wfi_done` is issued.
- Interrupt sources are assumed synchronous to `clock`. The block has no synchronizers.

## Configuration
- `WFI_CLK_GATE_EN` defined: `core_clk_en` is driven low in SLEEP as described.
- `WFI_CLK_GATE_EN` undefined: `core_clk_en` is tied to 1. The FSM, `wfi`, `wfi_stall` and `wfi_done` behave identically.

## Test plan
- Idle drain:
  - Stimulus: `wfi_req` at cycle 10 with outstanding=0 and no pending; `reg_mie`=0x80, `reg_mip`=0x80 at cycle 30.
  - Required: `wfi`=1 at cycle 12; `wfi`=0 at 31; `wfi_done` at 33 (WAKE_CYCLES=2).
- Drain wait:
  - Stimulus: `mem_outstanding`=1 for 20 cycles after `wfi_req`.
  - Required: `wfi` rises 1 cycle after `mem_outstanding` falls; `drain_timeout_err` stays 0.
- Timeout:
  - Stimulus: `DRAIN_TIMEOUT`=8, `fetch_outstanding` held 1.
  - Required: `drain_timeout_err`=1 at DRAIN+9 and stays set; `clint_int` then gives WAKE and `wfi_done`, with `wfi` never 1.
- NOP WFI:
  - Stimulus: `wfi_req` with `single_step`=1, then again with `debug_int`=1.
  - Required: both give `wfi_done` the next cycle; `wfi` and `wfi_stall` stay 0.
- Simultaneous:
  - Stimulus: `drained` and `bus_err_int` both rise in the same DRAIN cycle.
  - Required: go to WAKE; `wfi` never asserted.
- Reset:
  - Stimulus: `reset_n` low during SLEEP.
  - Required: `core_clk_en`=1 and `wfi`=0 asynchronously; after release, state is IDLE and `drain_timeout_err`=0.
  - Repeat with `WFI_CLK_GATE_EN` undefined: `core_clk_en` is constantly 1.

Source files
------------

// File: rtl/wfi_sleep_ctrl.sv
// WFI sleep sequencer: drains fetch/LSU traffic, raises wfi, optionally gates the core clock, wakes on any pending source.
// Latency: wfi_stall one cycle after wfi_req, wfi two cycles at the earliest; wfi_done WAKE_CYCLES+1 cycles after a wake source.
// Backpressure: holds pipeline issue via wfi_stall while draining/asleep/waking; wfi_req outside idle is dropped.
// Build option WFI_CLK_GATE_EN: when defined core_clk_en drops while asleep, otherwise it is tied high.
module wfi_sleep_ctrl #(
  parameter int PCWIDTH       = 32,
  parameter int DRAIN_TIMEOUT = 100,
  parameter int WAKE_CYCLES   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wfi_req,
  input  logic               fetch_outstanding,
  input  logic               mem_outstanding,
  input  logic [PCWIDTH-1:0] reg_mie,
  input  logic [PCWIDTH-1:0] reg_mip,
  input  logic               bus_err_int,
  input  logic               debug_int,
  input  logic               clint_int,
  input  logic               debug,
  input  logic               single_step,
  output logic               wfi,
  output logic               core_clk_en,
  output logic               wfi_stall,
  output logic               wfi_done,
  output logic               drain_timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  // Registered status outputs, all decoded from the next state.
  typedef struct packed {
    logic wfi;
    logic stall;
    logic done;
  } ctl_t;

  localparam logic [15:0] DRAIN_LIMIT = 16'(DRAIN_TIMEOUT);
  localparam logic [3:0]  WAKE_LAST   = 4'(WAKE_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] drain_cnt_q;
  logic [15:0] drain_cnt_d;
  logic [3:0]  wake_cnt_q;
  logic [3:0]  wake_cnt_d;
  logic        err_q;
  logic        err_d;
  logic        done_d;
  ctl_t        ctl_q;
  ctl_t        ctl_d;
  logic        pending;
  logic        drained;

  // Wake sources deliberately ignore mstatus.MIE: WFI must resume on any enabled+pending interrupt.
  assign pending = (|(reg_mie & reg_mip)) | bus_err_int | debug_int | clint_int;
  assign drained = ~fetch_outstanding & ~mem_outstanding;

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      wake_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state, counter and done-pulse decode; pending always beats drained.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wfi_req) begin
          if (pending | debug | single_step) begin
            // Nothing to sleep for: retire the WFI as a NOP.
            done_d = 1'b1;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (pending) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end else if (drained) begin
          state_d = ST_SLEEP;
        end else begin
          if (drain_cnt_q != 16'hFFFF) begin
            drain_cnt_d = drain_cnt_q + 16'd1;
          end
          // Flag a stuck drain but keep waiting; the error is sticky until reset.
          if (drain_cnt_q == DRAIN_LIMIT) begin
            err_d = 1'b1;
          end
        end
      end
      ST_SLEEP: begin
        if (pending) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Give the ungated clock WAKE_CYCLES cycles to settle before handing back.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    ctl_d       = '0;
    ctl_d.wfi   = (state_d == ST_SLEEP);
    ctl_d.stall = (state_d != ST_IDLE);
    ctl_d.done  = done_d;
  end

  // Output registers; reset clears them asynchronously so a sleeping core wakes at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  assign wfi               = ctl_q.wfi;
  assign wfi_stall         = ctl_q.stall;
  assign wfi_done          = ctl_q.done;
  assign drain_timeout_err = err_q;

`ifdef WFI_CLK_GATE_EN
  logic clk_en_q;

  // Close the core clock gate only while asleep; reset reopens it asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_en_q <= 1'b1;
    end else begin
      clk_en_q <= (state_d != ST_SLEEP);
    end
  end

  assign core_clk_en = clk_en_q;
`else
  assign core_clk_en = 1'b1;
`endif

endmodule

// File: tb/tb_wfi_sleep_ctrl.sv
// Bench for wfi_sleep_ctrl: two instances (default timing, and short timeout / longer wake) share stimulus.
// Directed scenarios check spec timing against constants; a random phase checks against a timestamp model.
module tb_wfi_sleep_ctrl;
  localparam int PCW  = 32;
  localparam int TO_A = 100;
  localparam int WC_A = 2;
  localparam int TO_B = 8;
  localparam int WC_B = 3;

  logic           clock;
  logic           reset_n;
  logic           wfi_req;
  logic           fetch_outstanding;
  logic           mem_outstanding;
  logic [PCW-1:0] reg_mie;
  logic [PCW-1:0] reg_mip;
  logic           bus_err_int;
  logic           debug_int;
  logic           clint_int;
  logic           debug;
  logic           single_step;
  logic [1:0]     o_wfi;
  logic [1:0]     o_clk_en;
  logic [1:0]     o_stall;
  logic [1:0]     o_done;
  logic [1:0]     o_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: phase flags plus cycle timestamps.
  int  to_p [2] = '{TO_A, TO_B};
  int  wc_p [2] = '{WC_A, WC_B};
  bit  m_drain [2];
  bit  m_sleep [2];
  bit  m_err [2];
  bit  m_done [2];
  int  m_dstart [2];
  int  m_wend [2];
  logic exp_clk [2];

  wfi_sleep_ctrl #(.PCWIDTH(PCW), .DRAIN_TIMEOUT(TO_A), .WAKE_CYCLES(WC_A)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .wfi_req(wfi_req),
    .fetch_outstanding(fetch_outstanding), .mem_outstanding(mem_outstanding),
    .reg_mie(reg_mie), .reg_mip(reg_mip), .bus_err_int(bus_err_int),
    .debug_int(debug_int), .clint_int(clint_int), .debug(debug), .single_step(single_step),
    .wfi(o_wfi[0]), .core_clk_en(o_clk_en[0]), .wfi_stall(o_stall[0]),
    .wfi_done(o_done[0]), .drain_timeout_err(o_err[0])
  );

  wfi_sleep_ctrl #(.PCWIDTH(PCW), .DRAIN_TIMEOUT(TO_B), .WAKE_CYCLES(WC_B)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .wfi_req(wfi_req),
    .fetch_outstanding(fetch_outstanding), .mem_outstanding(mem_outstanding),
    .reg_mie(reg_mie), .reg_mip(reg_mip), .bus_err_int(bus_err_int),
    .debug_int(debug_int), .clint_int(clint_int), .debug(debug), .single_step(single_step),
    .wfi(o_wfi[1]), .core_clk_en(o_clk_en[1]), .wfi_stall(o_stall[1]),
    .wfi_done(o_done[1]), .drain_timeout_err(o_err[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    wfi_req = 0; fetch_outstanding = 0; mem_outstanding = 0;
    reg_mie = '0; reg_mip = '0; bus_err_int = 0; debug_int = 0; clint_int = 0;
    debug = 0; single_step = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_drain[i] = 0; m_sleep[i] = 0; m_err[i] = 0; m_done[i] = 0;
      m_dstart[i] = 0; m_wend[i] = -1; exp_clk[i] = 1'b1;
    end
    cyc = 0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, return on the falling edge.
  task automatic tick();
    logic pend;
    logic drnd;
    @(posedge clock);
    pend = (|(reg_mie & reg_mip)) | bus_err_int | debug_int | clint_int;
    drnd = !fetch_outstanding && !mem_outstanding;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (m_drain[i]) begin
        if (pend) begin
          m_drain[i] = 0; m_wend[i] = cyc + 1 + wc_p[i];
        end else if (drnd) begin
          m_drain[i] = 0; m_sleep[i] = 1;
        end else if (cyc - m_dstart[i] == to_p[i]) begin
          m_err[i] = 1;
        end
      end else if (m_sleep[i]) begin
        if (pend) begin
          m_sleep[i] = 0; m_wend[i] = cyc + 1 + wc_p[i];
        end
      end else if (m_wend[i] >= 0) begin
        if (cyc + 1 == m_wend[i]) begin
          m_wend[i] = -1; m_done[i] = 1;
        end
      end else if (wfi_req) begin
        if (pend || debug || single_step) m_done[i] = 1;
        else begin
          m_drain[i] = 1; m_dstart[i] = cyc + 1;
        end
      end
`ifdef WFI_CLK_GATE_EN
      exp_clk[i] = !m_sleep[i];
`else
      exp_clk[i] = 1'b1;
`endif
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    model_clear();
    reset_n = 1'b1;
  endtask

  task automatic settle();
    set_idle();
    clint_int = 1; tick(); clint_int = 0;
    repeat (WC_B + 3) tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_wfi[i] !== 1'b0) begin failures++; $display("FAIL reset_wfi inst=%0d got=%b exp=0", i, o_wfi[i]); end
      checks++; if (o_clk_en[i] !== 1'b1) begin failures++; $display("FAIL reset_clk_en inst=%0d got=%b exp=1", i, o_clk_en[i]); end
      checks++; if (o_stall[i] !== 1'b0) begin failures++; $display("FAIL reset_stall inst=%0d got=%b exp=0", i, o_stall[i]); end
      checks++; if (o_done[i] !== 1'b0) begin failures++; $display("FAIL reset_done inst=%0d got=%b exp=0", i, o_done[i]); end
      checks++; if (o_err[i] !== 1'b0) begin failures++; $display("FAIL reset_err inst=%0d got=%b exp=0", i, o_err[i]); end
    end
  endtask

  task automatic test_idle_drain();
    while (cyc < 10) tick();
    wfi_req = 1; tick(); wfi_req = 0;
    checks++; if (o_stall[0] !== 1'b1) begin failures++; $display("FAIL idle_stall_rise got=%b exp=1", o_stall[0]); end
    checks++; if (o_wfi[0] !== 1'b0) begin failures++; $display("FAIL idle_wfi_c11 got=%b exp=0", o_wfi[0]); end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_wfi[i] !== 1'b1) begin failures++; $display("FAIL idle_wfi_c12 inst=%0d got=%b exp=1", i, o_wfi[i]); end
      checks++; if (o_clk_en[i] !== exp_clk[i]) begin failures++; $display("FAIL idle_clk_en_c12 inst=%0d got=%b exp=%b", i, o_clk_en[i], exp_clk[i]); end
    end
    while (cyc < 30) tick();
    reg_mie = 32'h80; reg_mip = 32'h80; tick(); reg_mie = '0; reg_mip = '0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_wfi[i] !== 1'b0) begin failures++; $display("FAIL idle_wfi_c31 inst=%0d got=%b exp=0", i, o_wfi[i]); end
      checks++; if (o_clk_en[i] !== 1'b1) begin failures++; $display("FAIL idle_clk_en_c31 inst=%0d got=%b exp=1", i, o_clk_en[i]); end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (o_done[0] !== 1'(k == 2)) begin failures++; $display("FAIL idle_done_a cyc=%0d got=%b exp=%b", cyc, o_done[0], k == 2); end
      checks++; if (o_done[1] !== 1'(k == 3)) begin failures++; $display("FAIL idle_done_b cyc=%0d got=%b exp=%b", cyc, o_done[1], k == 3); end
      checks++; if (o_stall[0] !== 1'(k < 2)) begin failures++; $display("FAIL idle_stall_a cyc=%0d got=%b exp=%b", cyc, o_stall[0], k < 2); end
    end
  endtask

  task automatic test_timeout();
    fetch_outstanding = 1; wfi_req = 1; tick(); wfi_req = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++; if (o_err[1] !== 1'(k >= TO_B + 1)) begin failures++; $display("FAIL timeout_err_b drain+%0d got=%b exp=%b", k, o_err[1], k >= TO_B + 1); end
      checks++; if (o_err[0] !== 1'b0) begin failures++; $display("FAIL timeout_err_a drain+%0d got=%b exp=0", k, o_err[0]); end
      checks++; if (o_wfi !== 2'b00) begin failures++; $display("FAIL timeout_wfi drain+%0d got=%b exp=00", k, o_wfi); end
    end
    clint_int = 1; tick(); clint_int = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (o_done[0] !== 1'(k == WC_A)) begin failures++; $display("FAIL timeout_done_a wake+%0d got=%b exp=%b", k, o_done[0], k == WC_A); end
      checks++; if (o_done[1] !== 1'(k == WC_B)) begin failures++; $display("FAIL timeout_done_b wake+%0d got=%b exp=%b", k, o_done[1], k == WC_B); end
      checks++; if (o_wfi !== 2'b00 || o_err[1] !== 1'b1) begin failures++; $display("FAIL timeout_after wfi=%b err_b=%b exp wfi=00 err_b=1", o_wfi, o_err[1]); end
    end
    fetch_outstanding = 0;
  endtask

  task automatic test_drain_wait();
    mem_outstanding = 1; wfi_req = 1; tick(); wfi_req = 0;
    repeat (19) begin
      tick();
      checks++; if (o_wfi !== 2'b00) begin failures++; $display("FAIL drain_wfi_early cyc=%0d got=%b exp=00", cyc, o_wfi); end
    end
    mem_outstanding = 0; tick();
    checks++; if (o_wfi !== 2'b11) begin failures++; $display("FAIL drain_wfi_rise got=%b exp=11", o_wfi); end
    checks++; if (o_err[0] !== 1'b0) begin failures++; $display("FAIL drain_no_timeout got=%b exp=0", o_err[0]); end
    checks++; if (o_err[1] !== 1'b1) begin failures++; $display("FAIL drain_short_timeout got=%b exp=1", o_err[1]); end
    settle();
  endtask

  task automatic test_nop();
    for (int t = 0; t < 2; t++) begin
      single_step = (t == 0); debug_int = (t == 1); wfi_req = 1; tick();
      wfi_req = 0; single_step = 0; debug_int = 0;
      checks++; if (o_done !== 2'b11) begin failures++; $display("FAIL nop_done case=%0d got=%b exp=11", t, o_done); end
      checks++; if (o_stall !== 2'b00 || o_wfi !== 2'b00) begin failures++; $display("FAIL nop_quiet case=%0d stall=%b wfi=%b exp=00", t, o_stall, o_wfi); end
      tick();
      checks++; if (o_done !== 2'b00 || o_stall !== 2'b00) begin failures++; $display("FAIL nop_after case=%0d done=%b stall=%b exp=00", t, o_done, o_stall); end
    end
  endtask

  task automatic test_simultaneous();
    fetch_outstanding = 1; wfi_req = 1; tick(); wfi_req = 0;
    repeat (2) tick();
    fetch_outstanding = 0; bus_err_int = 1; tick(); bus_err_int = 0;
    checks++; if (o_wfi !== 2'b00 || o_stall !== 2'b11) begin failures++; $display("FAIL simul_wake wfi=%b stall=%b exp wfi=00 stall=11", o_wfi, o_stall); end
    for (int k = 1; k <= WC_B + 1; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++; if (o_wfi[i] !== 1'b0) begin failures++; $display("FAIL simul_wfi inst=%0d got=%b exp=0", i, o_wfi[i]); end
        checks++; if (o_done[i] !== 1'(k == wc_p[i])) begin failures++; $display("FAIL simul_done inst=%0d wake+%0d got=%b exp=%b", i, k, o_done[i], k == wc_p[i]); end
      end
    end
  endtask

  task automatic test_random();
    bit busy;
    for (int n = 0; n < 1200; n++) begin
      busy = (n % 300) < 80;
      wfi_req           = ($urandom_range(0, 4) == 0);
      fetch_outstanding = busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      mem_outstanding   = ($urandom_range(0, 3) == 0);
      reg_mie           = ($urandom_range(0, 1) == 1) ? 32'h0000_0888 : 32'h0;
      reg_mip           = ($urandom_range(0, 14) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      bus_err_int       = ($urandom_range(0, 40) == 0);
      debug_int         = ($urandom_range(0, 40) == 0);
      clint_int         = ($urandom_range(0, 30) == 0);
      debug             = ($urandom_range(0, 12) == 0);
      single_step       = ($urandom_range(0, 12) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++; if (o_wfi[i] !== m_sleep[i]) begin failures++; $display("FAIL rnd_wfi inst=%0d cyc=%0d got=%b exp=%b", i, cyc, o_wfi[i], m_sleep[i]); end
        checks++; if (o_stall[i] !== (m_drain[i] | m_sleep[i] | (m_wend[i] >= 0))) begin failures++; $display("FAIL rnd_stall inst=%0d cyc=%0d got=%b", i, cyc, o_stall[i]); end
        checks++; if (o_done[i] !== m_done[i]) begin failures++; $display("FAIL rnd_done inst=%0d cyc=%0d got=%b exp=%b", i, cyc, o_done[i], m_done[i]); end
        checks++; if (o_err[i] !== m_err[i]) begin failures++; $display("FAIL rnd_err inst=%0d cyc=%0d got=%b exp=%b", i, cyc, o_err[i], m_err[i]); end
        checks++; if (o_clk_en[i] !== exp_clk[i]) begin failures++; $display("FAIL rnd_clk_en inst=%0d cyc=%0d got=%b exp=%b", i, cyc, o_clk_en[i], exp_clk[i]); end
      end
    end
    settle();
  endtask

  task automatic test_reset_sleep();
    wfi_req = 1; tick(); wfi_req = 0; tick();
    checks++; if (o_wfi !== 2'b11) begin failures++; $display("FAIL rst_pre_sleep got=%b exp=11", o_wfi); end
    checks++; if (o_err[1] !== 1'b1) begin failures++; $display("FAIL rst_pre_err got=%b exp=1", o_err[1]); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_wfi !== 2'b00) begin failures++; $display("FAIL rst_async_wfi got=%b exp=00", o_wfi); end
    checks++; if (o_clk_en !== 2'b11) begin failures++; $display("FAIL rst_async_clk_en got=%b exp=11", o_clk_en); end
    checks++; if (o_err !== 2'b00 || o_stall !== 2'b00) begin failures++; $display("FAIL rst_async_err_stall err=%b stall=%b exp=00", o_err, o_stall); end
    repeat (2) begin
      @(negedge clock);
      checks++; if (o_done !== 2'b00) begin failures++; $display("FAIL rst_no_done got=%b exp=00", o_done); end
    end
    model_clear();
    reset_n = 1'b1;
    tick();
    checks++; if (o_stall !== 2'b00 || o_wfi !== 2'b00 || o_err !== 2'b00) begin failures++; $display("FAIL rst_release stall=%b wfi=%b err=%b exp=00", o_stall, o_wfi, o_err); end
    clint_int = 1; wfi_req = 1; tick(); clint_int = 0; wfi_req = 0;
    checks++; if (o_done !== 2'b11 || o_stall !== 2'b00) begin failures++; $display("FAIL rst_idle_nop done=%b stall=%b exp done=11 stall=00", o_done, o_stall); end
  endtask

  initial begin
    reset_n = 1'b1;
    set_idle();
    model_clear();
    #2;
    do_reset();
    test_reset();
    test_idle_drain();
    settle();
    test_timeout();
    do_reset();
    test_drain_wait();
    test_nop();
    test_simultaneous();
    test_random();
    test_reset_sleep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
